// File: rtl/c7bifu_pkg.sv
// Shared definitions for the c7bifu instruction fetch path: fetch granule,
// address width, reset fetch address and the fetch FSM state encoding.
package c7bifu_pkg;

    localparam int          ADDR_W       = 32;
    localparam int          FETCH_BYTES  = 8;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HALT = 2'd3
    } fetch_state_e;

    // Drop the byte offset so the address names one 64-bit fetch granule.
    function automatic logic [31:0] align_fetch(input logic [31:0] addr);
        return {addr[31:3], 3'b000};
    endfunction

endpackage

// File: rtl/c7bifu_fetch.sv
// Fetch address generator and single-outstanding bus read master that feeds
// one 64-bit beat at a time into the instruction queue.
module c7bifu_fetch
    import c7bifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              iq_full,
    output logic              bus_req,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_ack,
    input  logic              bus_rdata_vld,
    input  logic [63:0]       bus_rdata,
    input  logic              bus_err,
    output logic [ADDR_W-1:0] data_addr,
    output logic [63:0]       data,
    output logic              data_vld,
    output logic              fetch_err,
    output logic [ADDR_W-1:0] fetch_err_addr
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              drop_q, drop_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [ADDR_W-1:0] data_addr_q, data_addr_d;
    logic [63:0]       data_q, data_d;
    logic              data_vld_q, data_vld_d;
    logic              fetch_err_q, fetch_err_d;
    logic [ADDR_W-1:0] fetch_err_addr_q, fetch_err_addr_d;
    logic [ADDR_W-1:0] flush_pc;

    // The word-select bit and byte offset of start_addr belong to the queue.
    logic unused_start_lsbs;
    assign unused_start_lsbs = ^start_addr[2:0];

    assign flush_pc = align_fetch(start_addr);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q          <= IDLE;
            pc_q             <= align_fetch(RESET_PC);
            drop_q           <= 1'b0;
            req_addr_q       <= '0;
            data_addr_q      <= '0;
            data_q           <= '0;
            data_vld_q       <= 1'b0;
            fetch_err_q      <= 1'b0;
            fetch_err_addr_q <= '0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            drop_q           <= drop_d;
            req_addr_q       <= req_addr_d;
            data_addr_q      <= data_addr_d;
            data_q           <= data_d;
            data_vld_q       <= data_vld_d;
            fetch_err_q      <= fetch_err_d;
            fetch_err_addr_q <= fetch_err_addr_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        drop_d           = drop_q;
        req_addr_d       = req_addr_q;
        data_addr_d      = data_addr_q;
        data_d           = data_q;
        data_vld_d       = 1'b0;
        fetch_err_d      = fetch_err_q;
        fetch_err_addr_d = fetch_err_addr_q;

        case (state_q)
            IDLE: begin
                // Waiting out a registered beat keeps the queue's free-slot count honest.
                if (!flush && !iq_full && !data_vld_q) begin
                    state_d    = REQ;
                    req_addr_d = pc_q;
                end
            end
            REQ: begin
                if (bus_ack) begin
                    state_d = WAIT;
                    if (flush) begin
                        drop_d = 1'b1;
                    end else if (!drop_q) begin
                        pc_d = pc_q + ADDR_W'(FETCH_BYTES);
                    end
                end else if (flush) begin
                    drop_d = 1'b1;
                end
            end
            WAIT: begin
                if (bus_rdata_vld) begin
                    state_d = IDLE;
                    drop_d  = 1'b0;
                    if (flush || drop_q) begin
                        state_d = IDLE;
                    end else if (bus_err) begin
                        state_d          = HALT;
                        fetch_err_d      = 1'b1;
                        fetch_err_addr_d = req_addr_q;
                    end else begin
                        data_d      = bus_rdata;
                        data_addr_d = req_addr_q;
                        data_vld_d  = 1'b1;
                    end
                end else if (flush) begin
                    drop_d = 1'b1;
                end
            end
            HALT: begin
                if (flush) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A redirect overrides every other pc/error/beat update.
        if (flush) begin
            pc_d        = flush_pc;
            fetch_err_d = 1'b0;
            data_vld_d  = 1'b0;
        end
    end

    assign bus_req        = (state_q == REQ);
    assign bus_addr       = req_addr_q;
    assign data_addr      = data_addr_q;
    assign data           = data_q;
    assign data_vld       = data_vld_q;
    assign fetch_err      = fetch_err_q;
    assign fetch_err_addr = fetch_err_addr_q;

endmodule
